// File: rtl/img_mem_writer_if.sv
// Signed 8-bit pixel stream with valid/ready handshake and end-of-frame marker.
interface img_mem_writer_if;
  logic              s_valid;
  logic              s_ready;
  logic signed [7:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/img_mem_writer.sv
// Scatters a channel-minor pixel stream into OC+1 banks; accepted beat is on the write port one cycle later.
// No back-pressure: s_ready stays high for the whole frame, and gaps in s_valid only stall the counters.
module img_mem_writer #(
  parameter int LOAD_ADDR_LEN = 7,
  parameter int OC            = 15,
  parameter int CHANNEL_SIZE  = 195
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  img_mem_writer_if.slave        pix,
  output logic [OC:0]            wr_en,
  output logic [LOAD_ADDR_LEN:0] wr_addr,
  output logic [7:0]             wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int AW = LOAD_ADDR_LEN + 1;
  localparam int CW = (OC > 0) ? $clog2(OC + 1) : 1;
  localparam logic [CW-1:0] CHAN_LAST = CW'(OC);
  localparam logic [AW-1:0] ADDR_LAST = AW'(CHANNEL_SIZE - 1);
  localparam logic [OC:0]   BANK0     = (OC + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] chan_cnt;
  logic [AW-1:0] addr_cnt;
  logic          accept;
  logic          last_pos;

  assign accept   = (state == WRITE) && pix.s_valid && pix.s_ready;
  assign last_pos = (chan_cnt == CHAN_LAST) && (addr_cnt == ADDR_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pix.s_ready <= 1'b0;
      wr_en       <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      chan_cnt    <= '0;
      addr_cnt    <= '0;
    end else begin
      wr_en <= '0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= WRITE;
            pix.s_ready <= 1'b1;
            busy        <= 1'b1;
            err         <= 1'b0;
            chan_cnt    <= '0;
            addr_cnt    <= '0;
          end
        end
        WRITE: begin
          if (accept) begin
            wr_en   <= BANK0 << chan_cnt;
            wr_addr <= addr_cnt;
            wr_data <= pix.s_data;
            // A frame ends on the marker or on the last slot, whichever comes first;
            // any disagreement between the two is a framing error.
            if (last_pos || pix.s_last) begin
              state       <= FLUSH;
              pix.s_ready <= 1'b0;
              if (last_pos != pix.s_last) err <= 1'b1;
            end else if (chan_cnt == CHAN_LAST) begin
              chan_cnt <= '0;
              addr_cnt <= addr_cnt + 1'b1;
            end else begin
              chan_cnt <= chan_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= ~err;
        end
        default: begin
          state       <= IDLE;
          pix.s_ready <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/img_mem_writer.md
Name: img_mem_writer

Overview:
- Write-side counterpart of the banked image memory (16 channel banks, DEPTH = CHANNEL_SIZE each).
- Accepts a signed 8-bit pixel stream over a valid/ready handshake.
- Scatters the pixels into the channel banks through one registered write port per bank.
- Sits between a layer's output (or the host loader) and the banked memory that the conv datapath reads through its dual read ports.

Parameters:
- LOAD_ADDR_LEN, 7, MSB index of bank address; address width is LOAD_ADDR_LEN+1 (8 bits).
- OC, 15, highest channel index; bank count is OC+1 (16).
- CHANNEL_SIZE, 195, entries per bank; valid addresses are 0..CHANNEL_SIZE-1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame write when idle.
- s_valid  in  1  stream beat valid.
- s_ready  out  1  stream beat accepted when s_valid && s_ready.
- s_data  in  8  signed pixel.
- s_last  in  1  marks the final beat of a frame.
- wr_en  out  OC+1  one-hot bank write enable; bit c writes bank c.
- wr_addr  out  LOAD_ADDR_LEN+1  write address, shared by all banks.
- wr_data  out  8  write data, shared by all banks.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last write of a clean frame.
- err  out  1  sticky framing error; cleared only by the next accepted start or by reset.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - s_ready, wr_en, busy, done and err all go to 0.
  - wr_addr, wr_data, chan_cnt and addr_cnt all go to 0.
- Reset mid-frame aborts immediately. No further writes occur and no done pulse is issued.
- Stream order is channel-minor. Beat k maps to channel k mod (OC+1) and address k div (OC+1).
  - For each address: channels 0..OC in turn, then the address increments.
  - A frame is (OC+1)*CHANNEL_SIZE beats (3120 at default parameters).
- State machine: IDLE, WRITE, FLUSH.
  - IDLE:
    - s_ready=0 and busy=0.
    - start=1 → WRITE. In the same edge: clear chan_cnt, addr_cnt and err; set busy.
  - WRITE:
    - s_ready=1 and busy=1.
    - On each accepted beat: chan_cnt increments.
    - When chan_cnt==OC, chan_cnt wraps to 0 and addr_cnt increments.
  - Last beat (chan_cnt==OC and addr_cnt==CHANNEL_SIZE-1):
    - If s_last=1 → FLUSH.
    - If s_last=0 → FLUSH and set err. The beat is still written; no wrap past CHANNEL_SIZE-1 ever occurs.
  - Early s_last (s_last=1 on any other beat): the beat is written, err is set, and the state goes to FLUSH.
  - FLUSH:
    - s_ready=0.
    - The final write is on the port this cycle.
    - Next edge → IDLE with busy=0. done=1 for one cycle only if err==0.
- start while busy (WRITE or FLUSH) is ignored.
- start and the reset edge together: reset wins.
- Write port latency:
  - A beat accepted at edge N drives wr_en/wr_addr/wr_data during cycle N+1 (registered outputs).
  - wr_en = 1<<chan of that beat.
  - wr_data = s_data unchanged; no width conversion or sign change.
- wr_en is all-zero in every cycle that follows an edge with no accepted beat. wr_addr and wr_data hold their last values.
- Back-pressure: none. The bank write completes in one cycle, so s_ready stays 1 for the whole of WRITE. Gaps in s_valid stall the counters only.
- Counter widths:
  - chan_cnt is $clog2(OC+1) bits.
  - addr_cnt is LOAD_ADDR_LEN+1 bits.
  - CHANNEL_SIZE must be ≤ 2^(LOAD_ADDR_LEN+1).

Test Plan:
- Reset/idle: hold rst=0, then release with no start.
  - Required: all outputs 0, s_ready=0 indefinitely.
  - Required: s_valid=1 causes no writes.
- Full frame, defaults: start, then 3120 beats with s_data=k[7:0] and s_last on beat 3119.
  - Beat 0: wr_en=16'h0001, addr 0, data 0x00.
  - Beat 17: wr_en=16'h0002, addr 1, data 0x11.
  - Beat 3119: wr_en=16'h8000, addr 194, data 0x2F.
  - Then done=1 for exactly one cycle, busy=0, err=0.
- Gapped valid (OC=1, CHANNEL_SIZE=4): toggle s_valid every other cycle.
  - Required: 8 writes to (bank,addr) = (0,0),(1,0),(0,1)..(1,3) in order.
  - Required: no wr_en in gap cycles; done one cycle after the 8th write.
- Early s_last (OC=1, CHANNEL_SIZE=4): s_last on beat 4.
  - Required: beat 4 written to bank 0, addr 2.
  - Required: err=1, no done, return to IDLE.
  - Required: next start clears err.
- Missing s_last (OC=1, CHANNEL_SIZE=4): s_last=0 on beat 7.
  - Required: beat 7 written to bank 1, addr 3.
  - Required: err=1, no done, s_ready=0 afterwards, no wrap to addr 0.
- Reset mid-frame at beat 100: assert rst=0 asynchronously.
  - Required: wr_en=0 and busy=0 immediately.
  - Required: a new start then writes beat 0 to bank 0, addr 0.
